// File: rtl/bcd_up_counter.sv
// ---------------------------------------------------------------------------
// bcd_up_counter
//   Multi-digit packed-BCD up counter. Counts 0 .. 10^DIGITS-1 and wraps to 0,
//   raising a sticky overflow flag on the wrap. The carry-out lets instances
//   be cascaded: co of a lower instance drives en of the next one, and both
//   share clk.
//
//   Optional feature macro: BCD_LOAD_EN
//     defined   -> load / load_val ports exist (synchronous parallel load)
//     undefined -> no load ports; priority is rst > clr > en > hold
//
// Parameters
//   DIGITS    number of BCD digits (1..8)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (count = 0, ovf = 0)
//   en        count enable
//   clr       synchronous clear of count and ovf
//   load      synchronous parallel load           (BCD_LOAD_EN only)
//   load_val  packed BCD load value, digit 0 [3:0] (BCD_LOAD_EN only)
//   count     registered packed BCD count, digit 0 (units) in [3:0]
//   co        combinational carry out: en AND every digit == 9
//   ovf       registered sticky overflow, set on the all-nines -> 0 wrap
// ---------------------------------------------------------------------------
module bcd_up_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
`ifdef BCD_LOAD_EN
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
`endif
  output logic [4*DIGITS-1:0]   count,
  output logic                  co,
  output logic                  ovf
);

`ifdef BCD_LOAD_EN
  // A nibble outside 0..9 loads as 0 so the digits can never go illegal.
  function automatic logic [3:0] bcd_filter(input logic [3:0] nib);
    if (nib > 4'd9) begin
      return 4'd0;
    end else begin
      return nib;
    end
  endfunction
`endif

  logic [4*DIGITS-1:0] count_q;
  logic [4*DIGITS-1:0] count_d;
  logic                ovf_q;
  logic                ovf_d;
  // step_s[i]: digit i steps this edge (en and all lower digits are 9).
  // step_s[DIGITS] is therefore en AND all-nines, i.e. the carry out.
  logic [DIGITS:0]     step_s;

  // Carry chain: decide which digits step on the next enabled edge.
  always_comb begin
    step_s    = '0;
    step_s[0] = en;
    for (int i = 0; i < DIGITS; i++) begin
      step_s[i+1] = step_s[i] & (count_q[4*i +: 4] == 4'd9);
    end
  end

  // Next-state: clr > load > en > hold.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end
`ifdef BCD_LOAD_EN
    else if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        count_d[4*i +: 4] = bcd_filter(load_val[4*i +: 4]);
      end
    end
`endif
    else if (en) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (step_s[i]) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            count_d[4*i +: 4] = 4'd0;
          end else begin
            count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          end
        end else begin
          count_d[4*i +: 4] = count_q[4*i +: 4];
        end
      end
      // Wrapping from all nines sets the sticky flag.
      if (step_s[DIGITS]) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      count_d = count_q;
      ovf_d   = ovf_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign co    = step_s[DIGITS];

endmodule

// File: tb/tb_bcd_up_counter.sv
module tb_bcd_up_counter;
  localparam int DIGITS = 2;
  localparam int MAXV   = 99;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
`ifdef BCD_LOAD_EN
  logic       load;
  logic [7:0] load_val;
`endif
  logic [7:0] count;
  logic       co;
  logic       ovf;

  int n_cmp;
  int n_bad;

  // Behavioural model: plain integer count and flag.
  int m_val;
  bit m_ovf;

  bcd_up_counter #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
`ifdef BCD_LOAD_EN
    .load     (load),
    .load_val (load_val),
`endif
    .count    (count),
    .co       (co),
    .ovf      (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[3:0] = 4'(v % 10);
    r[7:4] = 4'((v / 10) % 10);
    return r;
  endfunction

  function automatic int from_bcd_filtered(input logic [7:0] b);
    int d0;
    int d1;
    d0 = int'(b[3:0]);
    d1 = int'(b[7:4]);
    if (d0 > 9) d0 = 0;
    if (d1 > 9) d1 = 0;
    return d1 * 10 + d0;
  endfunction

  // Reference model update on the clock edge / async reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_val <= 0;
      m_ovf <= 1'b0;
    end else if (clr) begin
      m_val <= 0;
      m_ovf <= 1'b0;
    end
`ifdef BCD_LOAD_EN
    else if (load) begin
      m_val <= from_bcd_filtered(load_val);
    end
`endif
    else if (en) begin
      if (m_val == MAXV) begin
        m_val <= 0;
        m_ovf <= 1'b1;
      end else begin
        m_val <= m_val + 1;
      end
    end
  end

  // Per-cycle compare of DUT against model.
  always @(negedge clk) begin
    n_cmp++;
    if (count !== to_bcd(m_val) || ovf !== m_ovf ||
        co !== (en && !rst && m_val == MAXV)) begin
      n_bad++;
      $display("FAIL model_cmp t=%0t: got count=%h ovf=%b co=%b, want count=%h ovf=%b co=%b",
               $time, count, ovf, co, to_bcd(m_val), m_ovf, (en && !rst && m_val == MAXV));
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
`ifdef BCD_LOAD_EN
    load = 1'b0;
    load_val = 8'h00;
`endif
    #2;
    check("reset_count", count, 8'h00);
    check("reset_ovf", {7'd0, ovf}, 8'h00);
    check("reset_co", {7'd0, co}, 8'h00);

    @(negedge clk);
    rst = 1'b0;
    step(3);
    check("hold_en0", count, 8'h00);

    en = 1'b1;
    step(99);
    check("sweep_99", count, 8'h99);
    check("sweep_co", {7'd0, co}, 8'h01);
    step(1);
    check("wrap_count", count, 8'h00);
    check("wrap_ovf", {7'd0, ovf}, 8'h01);
    check("wrap_co", {7'd0, co}, 8'h00);
    step(5);
    check("post_wrap", count, 8'h05);
    check("ovf_sticky", {7'd0, ovf}, 8'h01);

    step(4);
    check("at_09", count, 8'h09);
    step(1);
    check("carry_10", count, 8'h10);
    for (int k = 0; k < 9; k++) begin
      step(1);
      check("digit1_stable", {4'd0, count[7:4]}, 8'h01);
    end
    check("at_19", count, 8'h19);
    step(1);
    check("carry_20", count, 8'h20);

    step(79);
    check("at_99_again", count, 8'h99);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_count", count, 8'h00);
    check("clr_ovf", {7'd0, ovf}, 8'h00);

`ifdef BCD_LOAD_EN
    load = 1'b1;
    load_val = 8'h47;
    step(1);
    load = 1'b0;
    check("load_47", count, 8'h47);
    step(1);
    check("after_load_48", count, 8'h48);
    load = 1'b1;
    load_val = 8'hA5;
    step(1);
    check("load_A5", count, 8'h05);
    load_val = 8'h9C;
    step(1);
    load = 1'b0;
    check("load_9C", count, 8'h90);
`endif

    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(36);
    check("at_36", count, 8'h36);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count", count, 8'h00);
    check("async_rst_ovf", {7'd0, ovf}, 8'h00);
    #1;
    rst = 1'b0;
    step(1);
    check("after_rst_01", count, 8'h01);
    en = 1'b0;
    step(2);
    check("hold_01", count, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_up_counter.md
# bcd_up_counter

Multi-digit packed-BCD up counter with enable, synchronous clear, carry-out for cascading and a sticky overflow flag. It counts upward from 0 to the all-nines value and wraps to 0. It is the counting-up complement of the team's mod-10 down counter, and it serves as the event and timestamp counter in the sample designs and their testbenches. An optional parallel-load port is compiled in by macro.

## Interface
- DIGITS, default 2: number of BCD digits; count range is 0 to 10^DIGITS−1; legal values are 1–8.
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high; clock is clk
- en  input  1  count enable; advance by one on the clk edge when high
- clr  input  1  synchronous clear of count and ovf
- load  input  1  synchronous parallel load; present only with BCD_LOAD_EN
- load_val  input  4*DIGITS  packed BCD load value, digit 0 in [3:0]; present only with BCD_LOAD_EN
- count  output  4*DIGITS  packed BCD count, digit 0 (units) in [3:0], registered
- co  output  1  carry out, combinational: en AND every digit == 9
- ovf  output  1  sticky overflow, registered

## Operation
- Per-edge priority: rst (async) > clr > load > en > hold.
- rst high: count = 0 and ovf = 0 immediately, with no clock needed. Both outputs hold while rst is high.
- clr: count ← 0 and ovf ← 0 on the edge. This applies regardless of en and load.
- load (BCD_LOAD_EN only): count ← load_val on the edge, and ovf is unchanged.
  - Any load_val nibble greater than 9 loads as 0 for that digit only.
- en high, no clr or load: standard BCD increment.
  - Digit 0 always steps.
  - Digit i steps only when en is high and digits 0..i−1 are all 9.
  - A stepping digit at 9 becomes 0; otherwise it becomes digit+1.
- Wrap: when count is all nines and en is high, the next count = 0 and ovf ← 1.
- ovf stays 1 until clr or rst.
- en low: count and ovf hold.
- Internal digits can never hold a value above 9. There is no illegal-state recovery path, because both the load filter and the reset guarantee legal values.
- Cascading: co of a lower instance drives en of the next instance. Both share clk.

## Timing
- Latency: count reflects an en/clr/load sampled at edge N immediately after edge N; there is no pipeline.
- co is combinational from the current count and en. It is high during the cycle before the wrap edge, and never during reset.
- ovf rises on the same edge at which count becomes 0 from all nines.
- Simultaneous events:
  - clr with en at all nines: result count = 0, ovf = 0 (clr wins).
  - load with en: the load wins and no increment is applied.
- rst asserted mid-count: outputs clear asynchronously.
- rst released: counting resumes on the first clk edge with en high after rst falls. No edge is consumed.
- Output reset values: count = 0, ovf = 0, co = 0.

## Configuration
- BCD_LOAD_EN defined: load and load_val ports exist, with the behaviour above.
- BCD_LOAD_EN undefined:
  - Neither port exists.
  - The priority reduces to rst > clr > en > hold.
  - All other behaviour is identical.

## Test plan
- Reset: with DIGITS = 2, rst = 1 at t = 0 with no clock gives count = 8'h00, ovf = 0, co = 0. Release rst, hold en = 0 for 3 edges → count stays 8'h00.
- Full sweep: en = 1 for 99 edges gives count = 8'h99 with co = 1 in that cycle. The next edge gives count = 8'h00, ovf = 1, co = 0. A further 5 edges give count = 8'h05 and ovf still 1.
- Digit carry: start from 8'h09 with en = 1 → one edge gives 8'h10. Start from 8'h19 → one edge gives 8'h20. Digit 1 must be unchanged on edges where digit 0 is not 9.
- Clear priority: at count = 8'h99 with en = 1 and ovf = 1, assert clr for one edge → count = 8'h00, ovf = 0.
- Load (BCD_LOAD_EN):
  - load_val = 8'h47 with en = 1 → count = 8'h47; the next en edge gives 8'h48.
  - load_val = 8'hA5 → count = 8'h05.
  - load_val = 8'h9C → count = 8'h90.
- Async reset mid-count: at count = 8'h36, pulse rst between edges → count = 8'h00 before the next edge. After release, the first en edge gives 8'h01.
